// File: rtl/fault_status_tracker.sv
// Status-flag front end for the RGB LED driver: fault debounce, node-pulse stretch, fault-service FSM.
// Define FAULT_COUNT_EN to expose the serviced-fault count on fault_count.
module fault_status_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 3125,
  parameter int unsigned NODE_STRETCH    = 312500,
  parameter int unsigned MAX_FAULTS      = 3
) (
  input  logic       clk_3125KHz,
  input  logic       rst,
  input  logic       fault_sense,
  input  logic       node_pulse,
  input  logic [1:0] unit_id,
  input  logic       pick_done,
  input  logic       drop_done,
  input  logic       path_end,
  output logic       fault_detect,
  output logic       block_picked,
  output logic       object_drop,
  output logic       node_flag,
  output logic       run_complete,
  output logic       EU_fault_flag,
  output logic       CU_fault_flag,
  output logic       RU_fault_flag
`ifdef FAULT_COUNT_EN
  ,
  output logic [1:0] fault_count
`endif
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NSW = $clog2(NODE_STRETCH + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NSW-1:0] NS_LOAD = NSW'(NODE_STRETCH);
  localparam logic [1:0]     MAX_Q   = 2'(MAX_FAULTS);

  typedef enum logic [2:0] {SEEK, FAULT, CARRY, DROP, DONE} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q;
  logic           db_q, db_d, db_prev_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [NSW-1:0] node_cnt_q, node_cnt_d;
  logic           node_flag_q, node_flag_d;
  logic [1:0]     serviced_q, serviced_d;
  logic           fault_detect_q, fault_detect_d;
  logic           block_picked_q, block_picked_d;
  logic           object_drop_q, object_drop_d;
  logic           run_complete_q, run_complete_d;
  logic           eu_q, eu_d, cu_q, cu_d, ru_q, ru_d;
  logic           fault_accept;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    node_cnt_d  = node_cnt_q;
    node_flag_d = node_pulse || (node_cnt_q > NSW'(1));
    if (node_pulse) begin
      node_cnt_d = NS_LOAD;
    end else if (node_cnt_q != '0) begin
      node_cnt_d = node_cnt_q - 1'b1;
    end
  end

  // Only the debounced rising edge counts; edges seen outside SEEK are dropped.
  assign fault_accept = db_q && !db_prev_q && (unit_id != 2'b00) && (serviced_q < MAX_Q);

  always_comb begin
    state_d       = state_q;
    serviced_d    = serviced_q;
    object_drop_d = object_drop_q;
    eu_d          = eu_q;
    cu_d          = cu_q;
    ru_d          = ru_q;
    case (state_q)
      SEEK: begin
        if (fault_accept) begin
          state_d       = FAULT;
          object_drop_d = 1'b0;
          if (unit_id == 2'b01) eu_d = 1'b1;
          if (unit_id == 2'b10) cu_d = 1'b1;
          if (unit_id == 2'b11) ru_d = 1'b1;
        end else if (path_end) begin
          state_d = DONE;
        end
      end
      FAULT: if (pick_done) state_d = CARRY;
      CARRY: begin
        if (drop_done) begin
          state_d = DROP;
          if (serviced_q != 2'd3) serviced_d = serviced_q + 2'd1;
        end
      end
      DROP: begin
        state_d       = SEEK;
        object_drop_d = 1'b1;
      end
      DONE:    state_d = DONE;
      default: state_d = SEEK;
    endcase
    fault_detect_d = (state_d == FAULT) || (state_d == CARRY);
    block_picked_d = (state_d == CARRY);
    run_complete_d = (state_d == DONE);
  end

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state_q        <= SEEK;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      db_q           <= 1'b0;
      db_prev_q      <= 1'b0;
      db_cnt_q       <= '0;
      node_cnt_q     <= '0;
      node_flag_q    <= 1'b0;
      serviced_q     <= '0;
      fault_detect_q <= 1'b0;
      block_picked_q <= 1'b0;
      object_drop_q  <= 1'b0;
      run_complete_q <= 1'b0;
      eu_q           <= 1'b0;
      cu_q           <= 1'b0;
      ru_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= fault_sense;
      sync2_q        <= sync1_q;
      db_q           <= db_d;
      db_prev_q      <= db_q;
      db_cnt_q       <= db_cnt_d;
      node_cnt_q     <= node_cnt_d;
      node_flag_q    <= node_flag_d;
      serviced_q     <= serviced_d;
      fault_detect_q <= fault_detect_d;
      block_picked_q <= block_picked_d;
      object_drop_q  <= object_drop_d;
      run_complete_q <= run_complete_d;
      eu_q           <= eu_d;
      cu_q           <= cu_d;
      ru_q           <= ru_d;
    end
  end

  assign fault_detect  = fault_detect_q;
  assign block_picked  = block_picked_q;
  assign object_drop   = object_drop_q;
  assign node_flag     = node_flag_q;
  assign run_complete  = run_complete_q;
  assign EU_fault_flag = eu_q;
  assign CU_fault_flag = cu_q;
  assign RU_fault_flag = ru_q;
`ifdef FAULT_COUNT_EN
  assign fault_count   = serviced_q;
`endif

endmodule

// File: tb/tb_fault_status_tracker.sv
// Scoreboard bench for fault_status_tracker (DEBOUNCE_CYCLES=4, NODE_STRETCH=8, MAX_FAULTS=2).
module tb_fault_status_tracker;

  logic       clk, rst, fault_sense, node_pulse, pick_done, drop_done, path_end;
  logic [1:0] unit_id;
  logic       fault_detect, block_picked, object_drop, node_flag, run_complete;
  logic       EU_fault_flag, CU_fault_flag, RU_fault_flag;
`ifdef FAULT_COUNT_EN
  logic [1:0] fault_count;
`endif

  fault_status_tracker #(.DEBOUNCE_CYCLES(4), .NODE_STRETCH(8), .MAX_FAULTS(2)) dut (
    .clk_3125KHz  (clk),
    .rst          (rst),
    .fault_sense  (fault_sense),
    .node_pulse   (node_pulse),
    .unit_id      (unit_id),
    .pick_done    (pick_done),
    .drop_done    (drop_done),
    .path_end     (path_end),
    .fault_detect (fault_detect),
    .block_picked (block_picked),
    .object_drop  (object_drop),
    .node_flag    (node_flag),
    .run_complete (run_complete),
    .EU_fault_flag(EU_fault_flag),
    .CU_fault_flag(CU_fault_flag),
    .RU_fault_flag(RU_fault_flag)
`ifdef FAULT_COUNT_EN
    ,
    .fault_count  (fault_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector bit order: {fault_detect, block_picked, object_drop, node_flag,
  //                             run_complete, EU, CU, RU}
  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   lat;

  function automatic logic [7:0] out_vec();
    return {fault_detect, block_picked, object_drop, node_flag,
            run_complete, EU_fault_flag, CU_fault_flag, RU_fault_flag};
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_total++;
      if (out_vec() === e.exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", e.name, out_vec(), e.exp);
    end
  end

  task automatic expect_out(input string name, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk_val(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure_lat(output int l);
    l = 0;
    while (!fault_detect && l < 20) begin
      tick(1);
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; fault_sense = 1'b0; node_pulse = 1'b0; unit_id = 2'b00;
    pick_done = 1'b0; drop_done = 1'b0; path_end = 1'b0;
    tick(2);
    expect_out("reset_held", 8'h00);
    rst = 1'b0;
    tick(1);
    expect_out("reset_release", 8'h00);

    // Debounce: 3-cycle glitch is rejected, a held level produces a fault after 7 edges.
    unit_id = 2'b01;
    fault_sense = 1'b1;
    for (int i = 0; i < 3; i++) begin expect_out("glitch_high", 8'h00); tick(1); end
    fault_sense = 1'b0;
    for (int i = 0; i < 4; i++) begin expect_out("glitch_low", 8'h00); tick(1); end
    fault_sense = 1'b1;
    measure_lat(lat);
    chk_val("debounce_latency", lat, 7);
    expect_out("eu_fault", 8'h84);
    pick_done = 1'b1; tick(1); pick_done = 1'b0;
    expect_out("eu_carry", 8'hC4);
    drop_done = 1'b1; tick(1); drop_done = 1'b0;
    expect_out("eu_drop_state", 8'h04);
    tick(1);
    expect_out("eu_object_drop", 8'h24);
    fault_sense = 1'b0;
    tick(8);
    expect_out("eu_idle", 8'h24);

    // Full service in CU; accepted fault clears object_drop.
    unit_id = 2'b10;
    fault_sense = 1'b1;
    measure_lat(lat);
    chk_val("cu_latency", lat, 7);
    expect_out("cu_fault", 8'h86);
    pick_done = 1'b1; tick(1); pick_done = 1'b0;
    expect_out("cu_carry", 8'hC6);
    drop_done = 1'b1; tick(1); drop_done = 1'b0;
    expect_out("cu_drop_state", 8'h06);
`ifdef FAULT_COUNT_EN
    chk_val("fault_count_two", int'(fault_count), 2);
`endif
    tick(1);
    expect_out("cu_object_drop", 8'h26);
    fault_sense = 1'b0;
    tick(8);

    // MAX_FAULTS reached: RU fault ignored, then path_end finishes the run.
    unit_id = 2'b11;
    fault_sense = 1'b1;
    tick(10);
    expect_out("ru_ignored", 8'h26);
    path_end = 1'b1; tick(1); path_end = 1'b0;
    expect_out("done_entered", 8'h2E);
    fault_sense = 1'b0;
    pick_done = 1'b1; tick(1); pick_done = 1'b0;
    tick(3);
    expect_out("done_held", 8'h2E);

    // Node stretch with retrigger at t=5.
    for (int t = 0; t <= 14; t++) begin
      expect_out($sformatf("node_t%0d", t), (t >= 1 && t <= 13) ? 8'h3E : 8'h2E);
      node_pulse = (t == 0 || t == 5);
      tick(1);
    end
    node_pulse = 1'b0;

    rst = 1'b1;
    expect_out("async_reset_done", 8'h00);
    tick(2);
    rst = 1'b0;
    expect_out("reset_after_done", 8'h00);

    // Simultaneous pick/drop in FAULT goes to CARRY; path_end there is ignored.
    unit_id = 2'b10;
    fault_sense = 1'b1;
    measure_lat(lat);
    chk_val("cu2_latency", lat, 7);
    expect_out("cu2_fault", 8'h82);
    pick_done = 1'b1; drop_done = 1'b1; tick(1); pick_done = 1'b0; drop_done = 1'b0;
    expect_out("pick_drop_same", 8'hC2);
    tick(1);
    expect_out("carry_stays", 8'hC2);
    path_end = 1'b1; tick(1); path_end = 1'b0;
    expect_out("path_end_in_carry", 8'hC2);
`ifdef FAULT_COUNT_EN
    chk_val("fault_count_zero_carry", int'(fault_count), 0);
`endif
    tick(1);

    // Asynchronous reset mid-CARRY, checked before any further clock edge.
    rst = 1'b1;
    expect_out("async_reset_carry", 8'h00);
    tick(2);
    rst = 1'b0;
    expect_out("reset_after_carry", 8'h00);
`ifdef FAULT_COUNT_EN
    chk_val("fault_count_reset", int'(fault_count), 0);
`endif
    unit_id = 2'b01;
    measure_lat(lat);
    chk_val("seek_after_reset_latency", lat, 7);
    expect_out("seek_after_reset", 8'h84);
    tick(1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
